// File: rtl/median3x3_filter.sv
// ---------------------------------------------------------------------------
// median3x3_filter
//   3x3 median filter placed between hdmi_rx and hdmi_tx, running in the
//   rx_clk domain. R, G and B are filtered independently. Two line buffers
//   and a 3x3 window feed a three-stage compare-only median network. Video
//   leaves the block exactly LAT (=6) clocks after it enters, and
//   dv/hs/vs are delayed by the same amount so they stay aligned.
//
//   Stream protocol: rx_dv is a valid-only qualifier (no ready/backpressure).
//   A pixel is accepted on every rising clk edge where rx_dv=1. tx_dv marks
//   the matching output pixel LAT clocks later.
//
//   Optional build macro: MEDIAN3X3_BYPASS_EN adds the 'bypass' input. When
//   it is high, the raw input pixel is delayed by LAT and passed through with
//   no median and no border forcing.
//
// Ports
//   clk                          pixel clock (rx_clk)
//   rst_n                        synchronous reset, active low
//   rx_red/rx_green/rx_blue [7:0] input pixel
//   rx_dv, rx_hs, rx_vs          active video, hsync, vsync (vs rise = new frame)
//   bypass                       (MEDIAN3X3_BYPASS_EN only) pass raw pixels
//   tx_red/tx_green/tx_blue [7:0] filtered pixel
//   tx_dv, tx_hs, tx_vs          rx_dv/hs/vs delayed LAT clocks
// ---------------------------------------------------------------------------
module median3x3_filter #(
  parameter int MAX_WIDTH = 2048,
  parameter int ADDR_W    = 11,
  parameter int LAT       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_red,
  input  logic [7:0] rx_green,
  input  logic [7:0] rx_blue,
  input  logic       rx_dv,
  input  logic       rx_hs,
  input  logic       rx_vs,
`ifdef MEDIAN3X3_BYPASS_EN
  input  logic       bypass,
`endif
  output logic [7:0] tx_red,
  output logic [7:0] tx_green,
  output logic [7:0] tx_blue,
  output logic       tx_dv,
  output logic       tx_hs,
  output logic       tx_vs
);

  // The column counter has one extra bit so it can hold MAX_WIDTH itself
  // (the saturated "past the line buffer" value).
  localparam int COL_W = ADDR_W + 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH);

  typedef logic [23:0] pix_t;

  // -------------------------------------------------------------------------
  // Compare-only helpers (unsigned 8-bit)
  // -------------------------------------------------------------------------
  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c);
    return min2(min2(a, b), c);
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // -------------------------------------------------------------------------
  // Position tracking
  // -------------------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [1:0]       line;
  logic             dv_q;
  logic             vs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
      dv_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      dv_q <= rx_dv;
      vs_q <= rx_vs;
      // Any dv gap restarts the column count, so a gap inside a line is
      // treated as the start of a new line.
      if (!rx_dv)
        col <= '0;
      else if (col != COL_MAX)
        col <= col + 1'b1;
      // vs rise clears the line count even if dv falls in the same cycle.
      if (rx_vs && !vs_q)
        line <= '0;
      else if (dv_q && !rx_dv && (line != 2'd3))
        line <= line + 2'd1;
    end
  end

  pix_t              rx_pix;
  logic              col_in;
  logic              border0;
  logic [ADDR_W-1:0] lb_addr;
  logic              lb_we;

  assign rx_pix  = {rx_red, rx_green, rx_blue};
  assign col_in  = (col < COL_MAX);
  assign border0 = !rx_dv || (line < 2'd2) || (col < COL_W'(2)) || !col_in;
  assign lb_addr = col[ADDR_W-1:0];
  assign lb_we   = rx_dv && col_in;

  // -------------------------------------------------------------------------
  // Line buffers: LB0 = previous line, LB1 = line before that.
  // Read-before-write at the same address; contents are never reset.
  // -------------------------------------------------------------------------
  pix_t lb0 [MAX_WIDTH];
  pix_t lb1 [MAX_WIDTH];
  pix_t lb0_q;
  pix_t lb1_q;

  always_ff @(posedge clk) begin
    lb0_q <= lb0[lb_addr];
    lb1_q <= lb1[lb_addr];
    if (lb_we) begin
      lb1[lb_addr] <= lb0[lb_addr];
      lb0[lb_addr] <= rx_pix;
    end
  end

  // -------------------------------------------------------------------------
  // Sync delay line; entry 0 also qualifies the window shift (stage 1 dv).
  // -------------------------------------------------------------------------
  logic [2:0] sync_sr [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) sync_sr[i] <= '0;
    end else begin
      sync_sr[0] <= {rx_dv, rx_hs, rx_vs};
      for (int i = 1; i < LAT; i++) sync_sr[i] <= sync_sr[i-1];
    end
  end

  assign tx_dv = sync_sr[LAT-1][2];
  assign tx_hs = sync_sr[LAT-1][1];
  assign tx_vs = sync_sr[LAT-1][0];

  // -------------------------------------------------------------------------
  // Data path: the median pipeline is fixed at 6 register stages
  //   E0 live/LB read -> E1 window -> E2 column sort -> E3 reduce
  //   -> E4 final med3 -> E5 output register
  // The border flag rides alongside in bord_sr and is applied at E5.
  // -------------------------------------------------------------------------
  pix_t       live_q;
  pix_t       win_top [3];   // LB1 row (oldest line)
  pix_t       win_mid [3];   // LB0 row
  pix_t       win_bot [3];   // live row; index 2 is the newest column
  logic [7:0] s1_hi [3][3];  // [column][channel]
  logic [7:0] s1_md [3][3];
  logic [7:0] s1_lo [3][3];
  logic [7:0] s2_a  [3];     // max of mins
  logic [7:0] s2_b  [3];     // med of mids
  logic [7:0] s2_c  [3];     // min of maxes
  pix_t       s3_pix;
  logic [4:0] bord_sr;
  pix_t       tx_pix;
`ifdef MEDIAN3X3_BYPASS_EN
  logic [4:0] byp_sr;
  pix_t       raw_sr [5];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q  <= '0;
      for (int j = 0; j < 3; j++) begin
        win_top[j] <= '0;
        win_mid[j] <= '0;
        win_bot[j] <= '0;
        s2_a[j]    <= '0;
        s2_b[j]    <= '0;
        s2_c[j]    <= '0;
        for (int k = 0; k < 3; k++) begin
          s1_hi[j][k] <= '0;
          s1_md[j][k] <= '0;
          s1_lo[j][k] <= '0;
        end
      end
      s3_pix  <= '0;
      bord_sr <= '1;   // forced border until real pixels arrive
      tx_pix  <= '0;
`ifdef MEDIAN3X3_BYPASS_EN
      byp_sr  <= '0;
      for (int j = 0; j < 5; j++) raw_sr[j] <= '0;
`endif
    end else begin
      live_q  <= rx_pix;
      bord_sr <= {bord_sr[3:0], border0};

      if (sync_sr[0][2]) begin
        for (int j = 0; j < 2; j++) begin
          win_top[j] <= win_top[j+1];
          win_mid[j] <= win_mid[j+1];
          win_bot[j] <= win_bot[j+1];
        end
        win_top[2] <= lb1_q;
        win_mid[2] <= lb0_q;
        win_bot[2] <= live_q;
      end

      for (int j = 0; j < 3; j++) begin
        for (int k = 0; k < 3; k++) begin
          s1_hi[j][k] <= max3(win_top[j][8*k +: 8], win_mid[j][8*k +: 8], win_bot[j][8*k +: 8]);
          s1_md[j][k] <= med3(win_top[j][8*k +: 8], win_mid[j][8*k +: 8], win_bot[j][8*k +: 8]);
          s1_lo[j][k] <= min3(win_top[j][8*k +: 8], win_mid[j][8*k +: 8], win_bot[j][8*k +: 8]);
        end
      end

      for (int k = 0; k < 3; k++) begin
        s2_a[k] <= max3(s1_lo[0][k], s1_lo[1][k], s1_lo[2][k]);
        s2_b[k] <= med3(s1_md[0][k], s1_md[1][k], s1_md[2][k]);
        s2_c[k] <= min3(s1_hi[0][k], s1_hi[1][k], s1_hi[2][k]);
      end

      for (int k = 0; k < 3; k++) begin
        s3_pix[8*k +: 8] <= med3(s2_a[k], s2_b[k], s2_c[k]);
      end

`ifdef MEDIAN3X3_BYPASS_EN
      byp_sr    <= {byp_sr[3:0], bypass};
      raw_sr[0] <= rx_pix;
      for (int j = 1; j < 5; j++) raw_sr[j] <= raw_sr[j-1];
      if (byp_sr[4])
        tx_pix <= raw_sr[4];
      else
        tx_pix <= bord_sr[4] ? '0 : s3_pix;
`else
      tx_pix <= bord_sr[4] ? '0 : s3_pix;
`endif
    end
  end

  assign tx_red   = tx_pix[23:16];
  assign tx_green = tx_pix[15:8];
  assign tx_blue  = tx_pix[7:0];

endmodule

// File: tb/tb_median3x3_filter.sv
// ---------------------------------------------------------------------------
// tb_median3x3_filter
//   Drives two filter instances with the same video: the default build
//   (MAX_WIDTH=2048) and a narrow one (MAX_WIDTH=8) that exercises the
//   line-buffer edge. Expected pixels are pushed per accepted input pixel
//   into one queue per instance; a negedge monitor pops them whenever
//   tx_dv is high. Syncs are compared against an input history 6 clocks old.
// ---------------------------------------------------------------------------
module tb_median3x3_filter;

  localparam int K_FLAT = 0;
  localparam int K_IMP  = 1;
  localparam int K_GRID = 2;
  localparam int K_RAMP = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_red = '0, rx_green = '0, rx_blue = '0;
  logic       rx_dv = 1'b0, rx_hs = 1'b0, rx_vs = 1'b0;
`ifdef MEDIAN3X3_BYPASS_EN
  logic       bypass = 1'b0;
`endif

  logic [7:0] tx_red, tx_green, tx_blue;
  logic       tx_dv, tx_hs, tx_vs;
  logic [7:0] n_red, n_green, n_blue;
  logic       n_dv, n_hs, n_vs;

  median3x3_filter dut (
    .clk(clk), .rst_n(rst_n),
    .rx_red(rx_red), .rx_green(rx_green), .rx_blue(rx_blue),
    .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
`ifdef MEDIAN3X3_BYPASS_EN
    .bypass(bypass),
`endif
    .tx_red(tx_red), .tx_green(tx_green), .tx_blue(tx_blue),
    .tx_dv(tx_dv), .tx_hs(tx_hs), .tx_vs(tx_vs)
  );

  median3x3_filter #(.MAX_WIDTH(8), .ADDR_W(3), .LAT(6)) dut_w8 (
    .clk(clk), .rst_n(rst_n),
    .rx_red(rx_red), .rx_green(rx_green), .rx_blue(rx_blue),
    .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
`ifdef MEDIAN3X3_BYPASS_EN
    .bypass(bypass),
`endif
    .tx_red(n_red), .tx_green(n_green), .tx_blue(n_blue),
    .tx_dv(n_dv), .tx_hs(n_hs), .tx_vs(n_vs)
  );

  // scoreboard state
  logic [23:0] exp_q[$];
  logic [23:0] exp_w8_q[$];
  logic [2:0]  hist_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        chk_zero = 1'b0;
  logic        chk_end = 1'b0;

  // ---- expected-value helpers (hand-derived rules per test pattern) ----
  function automatic logic [23:0] rep(input logic [7:0] v);
    return {v, v, v};
  endfunction

  function automatic logic [7:0] ramp_v(input int c);
    if (c < 8) return 8'((c + 1) * 16);
    return 8'hFF;
  endfunction

  function automatic logic [7:0] grid_v(input int c, input int l);
    case (l * 3 + c)
      0: return 8'd9;  1: return 8'd1;  2: return 8'd5;
      3: return 8'd3;  4: return 8'd7;  5: return 8'd2;
      6: return 8'd8;  7: return 8'd4;  default: return 8'd6;
    endcase
  endfunction

  function automatic logic [23:0] pix_of(input int kind, input int c, input int l);
    case (kind)
      K_FLAT:  return 24'h404040;
      K_IMP:   return (c == 5 && l == 4) ? 24'hFFFFFF : 24'h000000;
      K_GRID:  return rep(grid_v(c, l));
      default: return rep(ramp_v(c));
    endcase
  endfunction

  function automatic logic [23:0] exp_of(input int kind, input int c, input int l,
                                         input int max_w, input bit byp);
    bit inner;
    inner = (l >= 2) && (c >= 2) && (c < max_w);
    if (byp) return pix_of(kind, c, l);
    case (kind)
      K_FLAT:  return inner ? 24'h404040 : 24'h000000;
      K_IMP:   return 24'h000000;                       // isolated impulse is removed
      K_GRID:  return (l == 2 && c == 2) ? 24'h050505 : 24'h000000;
      default: return inner ? rep(ramp_v(c - 1)) : 24'h000000;  // middle column wins
    endcase
  endfunction

  // ---- driver tasks ----
  task automatic drive(input logic dv, input logic hs, input logic vs,
                       input logic [23:0] pix, input logic [23:0] e_big,
                       input logic [23:0] e_w8);
    rx_dv = dv; rx_hs = hs; rx_vs = vs;
    {rx_red, rx_green, rx_blue} = pix;
    if (dv && rst_n) begin
      exp_q.push_back(e_big);
      exp_w8_q.push_back(e_w8);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, vs, 24'h0, 24'h0, 24'h0);
  endtask

  task automatic frame(input int w, input int h, input int kind, input bit byp);
    idle(2, 1'b1);
    for (int l = 0; l < h; l++) begin
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
      for (int c = 0; c < w; c++)
        drive(1'b1, 1'b0, 1'b0, pix_of(kind, c, l),
              exp_of(kind, c, l, 2048, byp), exp_of(kind, c, l, 8, byp));
    end
    idle(4, 1'b0);
  endtask

  // ---- input history for sync alignment ----
  always @(posedge clk) begin
    if (!rst_n) hist_q.delete();
    else begin
      hist_q.push_back({rx_dv, rx_hs, rx_vs});
      if (hist_q.size() > 8) void'(hist_q.pop_front());
    end
  end

  // ---- monitor / scoreboard ----
  always @(negedge clk) begin
    logic [23:0] e;
    logic [2:0]  es;
    if (chk_zero) begin
      n_chk++;
      if ({tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs} != '0 ||
          {n_red, n_green, n_blue, n_dv, n_hs, n_vs} != '0) begin
        n_fail++;
        $display("FAIL reset_zero t=%0t got %h/%b%b%b and %h/%b%b%b, want all 0", $time,
                 {tx_red, tx_green, tx_blue}, tx_dv, tx_hs, tx_vs,
                 {n_red, n_green, n_blue}, n_dv, n_hs, n_vs);
      end
    end
    if (rst_n && hist_q.size() >= 6) begin
      es = hist_q[hist_q.size() - 6];
      n_chk++;
      if ({tx_dv, tx_hs, tx_vs} != es || {n_dv, n_hs, n_vs} != es) begin
        n_fail++;
        $display("FAIL sync_delay t=%0t got %b%b%b / %b%b%b want %b", $time,
                 tx_dv, tx_hs, tx_vs, n_dv, n_hs, n_vs, es);
      end
    end
    if (tx_dv) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_unexpected t=%0t got %h with empty queue", $time,
                 {tx_red, tx_green, tx_blue});
      end else begin
        e = exp_q.pop_front();
        if ({tx_red, tx_green, tx_blue} != e) begin
          n_fail++;
          $display("FAIL pix t=%0t got %h want %h", $time, {tx_red, tx_green, tx_blue}, e);
        end
      end
    end
    if (n_dv) begin
      n_chk++;
      if (exp_w8_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_w8_unexpected t=%0t got %h with empty queue", $time,
                 {n_red, n_green, n_blue});
      end else begin
        e = exp_w8_q.pop_front();
        if ({n_red, n_green, n_blue} != e) begin
          n_fail++;
          $display("FAIL pix_w8 t=%0t got %h want %h", $time, {n_red, n_green, n_blue}, e);
        end
      end
    end
    if (chk_end) begin
      n_chk++;
      if (exp_q.size() != 0 || exp_w8_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover got %0d/%0d pending want 0/0", exp_q.size(), exp_w8_q.size());
      end
    end
  end

  // ---- test sequence ----
  initial begin
    // 1: reset with live pattern, outputs stay 0 through reset and 6 clk after
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero = 1'b1;
    for (int i = 0; i < 4; i++)
      drive(1'b1, i[0], i[1], 24'h123456 ^ 24'(i * 24'h0F0F0F), 24'h0, 24'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b0, 1'b0, 24'hA5A5A5 + 24'(i), 24'h0, 24'h0);
    chk_zero = 1'b0;
    idle(3, 1'b0);

    // 2: flat 16x8 frame (narrow instance also blanks cols >= 8)
    frame(16, 8, K_FLAT, 1'b0);
    // 3: single white impulse at (5,4) is removed
    frame(16, 8, K_IMP, 1'b0);
    // 4: 3x3 window {9,1,5},{3,7,2},{8,4,6} -> centre 5
    frame(3, 3, K_GRID, 1'b0);
    // 5: 12-pixel ramp lines; narrow instance must not corrupt cols 2..7
    frame(12, 4, K_RAMP, 1'b0);
`ifdef MEDIAN3X3_BYPASS_EN
    // 6: bypass passes the impulse through unfiltered
    bypass = 1'b1;
    frame(16, 8, K_IMP, 1'b1);
    idle(8, 1'b0);
    bypass = 1'b0;
`endif
    idle(12, 1'b0);
    chk_end = 1'b1;
    @(negedge clk); #1;
    chk_end = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
